// File: rtl/eth_tx_pacer_if.sv
// Frame handshake between the TX sender and the pacer: request/active in, grant/strobe/busy out.
// The sender holds frame_req until start_grant; no grant is issued while busy.
interface eth_tx_pacer_if;
  logic frame_req;
  logic frame_active;
  logic start_grant;
  logic adv_data;
  logic busy;

  modport master (
    output frame_req,
    output frame_active,
    input  start_grant,
    input  adv_data,
    input  busy
  );

  modport slave (
    input  frame_req,
    input  frame_active,
    output start_grant,
    output adv_data,
    output busy
  );
endinterface

// File: rtl/eth_tx_pacer.sv
// PHY reset sequencing, debounced speed select, per-speed byte strobe and frame grant with IFG.
// All outputs registered (1-cycle latency); frame_req waits in IDLE while phy_ready is low or the gap runs.
module eth_tx_pacer #(
  parameter int RST_CNT_W = 25,
  parameter int DIV_10M   = 100,
  parameter int DIV_100M  = 10,
  parameter int DBNC_W    = 10,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk125MHz,
  input  logic       rstb,
  input  logic       phy_reset_req,
  input  logic       link_10mb,
  input  logic       link_100mb,
  input  logic       link_1000mb,
  input  logic       force_speed_en,
  input  logic [1:0] force_speed,
  output logic       eth_rst_b,
  output logic       phy_ready,
  output logic [1:0] speed,
  output logic       speed_changed,
  eth_tx_pacer_if.slave tx
);

  localparam int DIV_MAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
  localparam int DIV_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam int GAP_W   = (IFG_BYTES > 2) ? $clog2(IFG_BYTES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  logic [RST_CNT_W-1:0] rst_cnt;
  logic [2:0]           link_meta;
  logic [2:0]           link_sync;
  logic [1:0]           cand;
  logic [1:0]           cand_q;
  logic [DBNC_W-1:0]    dbnc_cnt;
  logic                 pending;
  logic                 upd;
  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     div_last;
  logic                 adv_q;
  logic [1:0]           state;
  logic                 fa_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 grant_q;

  // Counter parks once the top bit is set; a request restarts the whole sequence.
  always_ff @(posedge clk125MHz or posedge rstb) begin
    if (rstb) begin
      rst_cnt   <= '0;
      eth_rst_b <= 1'b0;
      phy_ready <= 1'b0;
    end else begin
      if (phy_reset_req)
        rst_cnt <= '0;
      else if (!rst_cnt[RST_CNT_W-1])
        rst_cnt <= rst_cnt + RST_CNT_W'(1);
      eth_rst_b <= rst_cnt[RST_CNT_W-1] | rst_cnt[RST_CNT_W-2];
      phy_ready <= rst_cnt[RST_CNT_W-1];
    end
  end

  always_ff @(posedge clk125MHz or posedge rstb) begin
    if (rstb) begin
      link_meta <= '0;
      link_sync <= '0;
    end else begin
      link_meta <= {link_1000mb, link_100mb, link_10mb};
      link_sync <= link_meta;
    end
  end

  always_comb begin
    cand = speed;
    if (force_speed_en)
      cand = force_speed;
    else if (link_sync[2])
      cand = 2'b11;
    else if (link_sync[1])
      cand = 2'b10;
    else if (link_sync[0])
      cand = 2'b01;
  end

  always_ff @(posedge clk125MHz or posedge rstb) begin
    if (rstb) begin
      cand_q   <= 2'b11;
      dbnc_cnt <= '0;
    end else begin
      cand_q <= cand;
      if (cand != cand_q)
        dbnc_cnt <= '0;
      else if (!(&dbnc_cnt))
        dbnc_cnt <= dbnc_cnt + DBNC_W'(1);
    end
  end

  // cand==cand_q guards the cycle where a saturated counter sees a fresh candidate.
  assign pending = (cand != speed) && (force_speed_en || ((&dbnc_cnt) && (cand == cand_q)));
  assign upd     = pending && (state == ST_IDLE) && !tx.frame_active;

  always_ff @(posedge clk125MHz or posedge rstb) begin
    if (rstb) begin
      speed         <= 2'b11;
      speed_changed <= 1'b0;
    end else begin
      speed_changed <= upd;
      if (upd)
        speed <= cand;
    end
  end

  assign div_last = (speed == 2'b01) ? DIV_W'(DIV_10M - 1) : DIV_W'(DIV_100M - 1);

  always_ff @(posedge clk125MHz or posedge rstb) begin
    if (rstb) begin
      div_cnt <= '0;
      adv_q   <= 1'b0;
    end else begin
      if (upd || (speed == 2'b00) || (speed == 2'b11) || (div_cnt == div_last))
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DIV_W'(1);
      adv_q <= (speed != 2'b00) && (div_cnt == '0);
    end
  end

  // An unsolicited frame in IDLE skips the grant and is tracked like a granted one.
  always_ff @(posedge clk125MHz or posedge rstb) begin
    if (rstb) begin
      state   <= ST_IDLE;
      fa_q    <= 1'b0;
      gap_cnt <= '0;
      grant_q <= 1'b0;
    end else begin
      fa_q    <= tx.frame_active;
      grant_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx.frame_active) begin
            state <= ST_ACTIVE;
          end else if (tx.frame_req && phy_ready) begin
            state   <= ST_GRANT;
            grant_q <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (tx.frame_active)
            state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (fa_q && !tx.frame_active) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (adv_q) begin
            if (gap_cnt == GAP_W'(IFG_BYTES - 1))
              state <= ST_IDLE;
            else
              gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx.adv_data    = adv_q;
  assign tx.start_grant = grant_q;
  assign tx.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_pacer.sv
// Bench for eth_tx_pacer: reset-timing table, strobe/debounce/deferral/IFG sequences,
// and randomized frames checked against an arithmetic strobe and gap model.
module tb_eth_tx_pacer;
  localparam int RST_CNT_W = 6;
  localparam int DIV_10M   = 20;
  localparam int DIV_100M  = 10;
  localparam int DBNC_W    = 4;
  localparam int IFG_BYTES = 12;

  logic       clk125MHz      = 1'b0;
  logic       rstb           = 1'b1;
  logic       phy_reset_req  = 1'b0;
  logic       link_10mb      = 1'b0;
  logic       link_100mb     = 1'b0;
  logic       link_1000mb    = 1'b0;
  logic       force_speed_en = 1'b0;
  logic [1:0] force_speed    = 2'b00;
  logic       eth_rst_b;
  logic       phy_ready;
  logic [1:0] speed;
  logic       speed_changed;

  eth_tx_pacer_if tx ();

  eth_tx_pacer #(
    .RST_CNT_W (RST_CNT_W),
    .DIV_10M   (DIV_10M),
    .DIV_100M  (DIV_100M),
    .DBNC_W    (DBNC_W),
    .IFG_BYTES (IFG_BYTES)
  ) dut (
    .clk125MHz      (clk125MHz),
    .rstb           (rstb),
    .phy_reset_req  (phy_reset_req),
    .link_10mb      (link_10mb),
    .link_100mb     (link_100mb),
    .link_1000mb    (link_1000mb),
    .force_speed_en (force_speed_en),
    .force_speed    (force_speed),
    .eth_rst_b      (eth_rst_b),
    .phy_ready      (phy_ready),
    .speed          (speed),
    .speed_changed  (speed_changed),
    .tx             (tx)
  );

  always #5 clk125MHz = ~clk125MHz;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int   n;          // clock edges after the counter (re)starts
    logic exp_rst_b;
    logic exp_ready;
  } rst_vec_t;

  rst_vec_t rst_tab[6];

  task automatic tick();
    @(posedge clk125MHz);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe from the spec rules: after a speed update at edge u, high on the
  // first following edge and every DIV edges after that.
  function automatic logic model_adv(input int t, input int u, input int spd);
    int d;
    if (spd == 3) return 1'b1;
    if (spd == 0) return 1'b0;
    d = (spd == 1) ? DIV_10M : DIV_100M;
    return ((t - u - 1) % d) == 0;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cnt, first, pulses, bad, u, t, spd, cur, sum, len, w;
    logic exp_busy;

    rst_tab[0] = '{1,  1'b0, 1'b0};
    rst_tab[1] = '{16, 1'b0, 1'b0};
    rst_tab[2] = '{17, 1'b1, 1'b0};
    rst_tab[3] = '{32, 1'b1, 1'b0};
    rst_tab[4] = '{33, 1'b1, 1'b1};
    rst_tab[5] = '{50, 1'b1, 1'b1};

    tx.frame_req    = 1'b0;
    tx.frame_active = 1'b0;

    repeat (3) @(posedge clk125MHz);
    #1;
    chk("rst_eth_rst_b", eth_rst_b, 0);
    chk("rst_phy_ready", phy_ready, 0);
    chk("rst_speed", speed, 3);
    chk("rst_adv_data", tx.adv_data, 0);
    chk("rst_start_grant", tx.start_grant, 0);
    chk("rst_speed_changed", speed_changed, 0);
    chk("rst_busy", tx.busy, 0);

    // PHY reset timing, then the same timing again after phy_reset_req.
    rstb = 1'b0;
    cyc  = 0;
    base = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 6; i++) begin
        while (cyc < base + rst_tab[i].n) tick();
        chk($sformatf("phy_rst_b_p%0d_n%0d", pass, rst_tab[i].n), eth_rst_b, rst_tab[i].exp_rst_b);
        chk($sformatf("phy_ready_p%0d_n%0d", pass, rst_tab[i].n), phy_ready, rst_tab[i].exp_ready);
      end
      if (pass == 0) begin
        phy_reset_req = 1'b1;
        tick();
        phy_reset_req = 1'b0;
        base = cyc;
      end
    end

    // Strobe rates under forced speed.
    force_speed_en = 1'b1;
    force_speed    = 2'b10;
    tick(); tick();
    chk("force_100_speed", speed, 2);
    cnt = 0;
    repeat (100) begin tick(); cnt += int'(tx.adv_data); end
    chk("adv_rate_100m", cnt, 10);

    force_speed = 2'b01;
    tick(); tick();
    cnt = 0;
    repeat (100) begin tick(); cnt += int'(tx.adv_data); end
    chk("adv_rate_10m", cnt, 5);

    force_speed = 2'b11;
    tick(); tick();
    cnt = 0;
    repeat (50) begin tick(); cnt += int'(tx.adv_data); end
    chk("adv_rate_1000m", cnt, 50);

    force_speed = 2'b00;
    tick(); tick();
    chk("force_off_speed", speed, 0);
    cnt = 0;
    repeat (50) begin tick(); cnt += int'(tx.adv_data); end
    chk("adv_rate_off", cnt, 0);

    // Debounce: 2 sync + 16 stable + 1 update edges.
    force_speed = 2'b11;
    tick(); tick();
    force_speed_en = 1'b0;
    repeat (3) tick();
    link_100mb = 1'b1;
    first  = 0;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (speed == 2'b10 && first == 0) first = n;
      pulses += int'(speed_changed);
    end
    chk("dbnc_latency", first, 19);
    chk("dbnc_pulse_count", pulses, 1);

    link_1000mb = 1'b1;
    repeat (10) tick();
    link_1000mb = 1'b0;
    pulses = 0;
    bad    = 0;
    repeat (40) begin
      tick();
      pulses += int'(speed_changed);
      if (speed != 2'b10) bad++;
    end
    chk("glitch_speed_hold", bad, 0);
    chk("glitch_no_pulse", pulses, 0);

    // Deferral: a new link speed during a frame waits for IDLE.
    tx.frame_req = 1'b1;
    tick();
    chk("defer_grant", tx.start_grant, 1);
    tx.frame_req    = 1'b0;
    tx.frame_active = 1'b1;
    tick();
    chk("defer_busy", tx.busy, 1);
    link_10mb  = 1'b1;
    link_100mb = 1'b0;
    repeat (40) tick();
    chk("defer_hold_active", speed, 2);
    tx.frame_active = 1'b0;
    for (int n = 0; n < 400 && tx.busy; n++) tick();
    chk("defer_gap_exit", tx.busy, 0);
    chk("defer_hold_gap", speed, 2);
    tick();
    chk("defer_applied", speed, 1);
    chk("defer_changed_pulse", speed_changed, 1);

    // Randomized frames at random speeds against the strobe/gap model.
    force_speed_en = 1'b1;
    cur = 1;
    for (int it = 0; it < 6; it++) begin
      spd = $urandom_range(1, 3);
      if (spd == cur) spd = (spd % 3) + 1;
      force_speed = spd[1:0];
      tick();
      u   = cyc;
      cur = spd;
      chk("rnd_speed", speed, spd);
      w = $urandom_range(0, 15);
      repeat (w) begin tick(); chk("rnd_adv_idle", tx.adv_data, model_adv(cyc, u, cur)); end
      tx.frame_req = 1'b1;
      tick();
      chk("rnd_grant", tx.start_grant, 1);
      chk("rnd_adv_grant", tx.adv_data, model_adv(cyc, u, cur));
      tx.frame_req    = 1'b0;
      tx.frame_active = 1'b1;
      len = $urandom_range(1, 20);
      repeat (len) begin tick(); chk("rnd_adv_active", tx.adv_data, model_adv(cyc, u, cur)); end
      tx.frame_active = 1'b0;
      tick();
      t = cyc;
      chk("rnd_busy_fall", tx.busy, 1);
      sum = 0;
      for (int k = 1; k < 2000; k++) begin
        sum += int'(model_adv(t + k - 1, u, cur));
        tick();
        exp_busy = (sum < IFG_BYTES);
        chk("rnd_adv_gap", tx.adv_data, model_adv(cyc, u, cur));
        chk("rnd_busy_gap", tx.busy, exp_busy);
        if (!exp_busy) break;
      end
    end

    // IFG at 1000M with frame_req held through the gap.
    force_speed = 2'b11;
    tick(); tick();
    tx.frame_req = 1'b1;
    tick();
    chk("ifg_first_grant", tx.start_grant, 1);
    tx.frame_active = 1'b1;
    repeat (5) tick();
    tx.frame_active = 1'b0;
    tick();
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      if (!tx.busy || tx.start_grant) bad++;
    end
    chk("ifg_busy_through_gap", bad, 0);
    tick();
    chk("ifg_idle_at_t12", tx.busy, 0);
    chk("ifg_no_grant_t12", tx.start_grant, 0);
    tick();
    chk("ifg_grant_t13", tx.start_grant, 1);
    pulses = 0;
    repeat (20) begin tick(); pulses += int'(tx.start_grant); end
    chk("ifg_single_grant", pulses, 0);

    // Unsolicited frame, then async reset while ACTIVE.
    tx.frame_req    = 1'b0;
    tx.frame_active = 1'b1;
    repeat (3) tick();
    tx.frame_active = 1'b0;
    for (int n = 0; n < 100 && tx.busy; n++) tick();
    chk("pre_unsol_idle", tx.busy, 0);
    force_speed = 2'b10;
    tick(); tick();
    chk("pre_unsol_speed", speed, 2);
    tx.frame_active = 1'b1;
    tick();
    chk("unsol_busy", tx.busy, 1);
    chk("unsol_no_grant", tx.start_grant, 0);
    tick();
    #2;
    rstb = 1'b1;
    #1;
    chk("arst_busy", tx.busy, 0);
    chk("arst_speed", speed, 3);
    chk("arst_eth_rst_b", eth_rst_b, 0);
    chk("arst_phy_ready", phy_ready, 0);
    chk("arst_start_grant", tx.start_grant, 0);
    chk("arst_adv_data", tx.adv_data, 0);
    chk("arst_speed_changed", speed_changed, 0);
    tick();
    chk("arst_hold_busy", tx.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
